router_sequencer: RTL
=====================

Name: router_sequencer

Overview:
- Controller that configures the output router.
- Front-panel route requests are staged in a shadow table. On commit, the block walks the output channels in order and reprograms only the ones whose source changed.
- Each reroute is glitch-free: the output is blanked, the router is written with a one-cycle update pulse, the block waits for settling, then the output is re-enabled.
- Sits between the frontpanel controller and the router's src_select_in/dest_select_in/update_in/output_active_in ports.

Parameters:
- W_SEL, 4, width of source/destination select fields (matches router).
- N_IN, 8, number of router input channels; valid src is 0..N_IN-1.
- N_OUT, 8, number of router output channels; valid dest is 0..N_OUT-1.
- ACTV_INIT, 1, reset value of every output activation bit.
- BLANK_CYCLES, 4, length in cycles of the blank and settle intervals; legal range 1..255.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset; synchronous and active-low.
- req_valid_in  in  1  route request valid.
- req_ready_out  out  1  request accepted when valid and ready are both high.
- req_src_in  in  W_SEL  requested source channel.
- req_dest_in  in  W_SEL  destination channel being configured.
- req_actv_in  in  1  requested activation for the destination.
- commit_in  in  1  single-cycle pulse: apply all staged entries.
- err_clr_in  in  1  clears err_out.
- busy_out  out  1  high whenever the FSM is not in IDLE.
- done_out  out  1  one-cycle pulse when a commit finishes.
- err_out  out  1  sticky flag: an out-of-range request was received.
- src_select_out  out  W_SEL  drives router src_select_in.
- dest_select_out  out  W_SEL  drives router dest_select_in.
- update_out  out  1  drives router update_in; one-cycle pulse per write.
- output_active_out  out  N_OUT  drives router output_active_in.

Behaviour:
- Reset (rst_n_in=0 at a clk_in edge):
  - staged src and live src = 0 for all entries; staged actv = ACTV_INIT.
  - output_active_out = {N_OUT{ACTV_INIT}}.
  - update_out=0, src/dest_select_out=0, done_out=0, err_out=0, FSM=IDLE.
  - Reset mid-sequence aborts immediately with the same values. The router is not rewritten, so the live table reads 0, consistent with the router's own init.
- All outputs are registered. req_ready_out = (state==IDLE).
- Request accept:
  - If dest<N_OUT and src<N_IN: staged[dest] <= {src, actv}.
  - Otherwise the request is dropped and err_out is set.
  - Repeated writes to the same dest: last one wins.
  - Requests are not accepted while busy.
- err_out stays set until err_clr_in. If a set and a clear happen in the same cycle, the set wins.
- commit_in in IDLE → SCAN with idx=0. If a request is accepted in the same cycle, it is staged first and included in that commit. commit_in while busy is ignored.
- SCAN (1 cycle per idx):
  - If staged src != live src[idx]: output_active_out[idx] <= 0, counter <= BLANK_CYCLES, go to BLANK.
  - Otherwise: output_active_out[idx] <= staged actv[idx], then advance.
  - Advance means idx++; after idx=N_OUT-1 go to DONE.
- BLANK: count down BLANK_CYCLES cycles, then go to WRITE.
- WRITE (1 cycle): update_out=1, src_select_out=staged src, dest_select_out=idx, live src[idx] <= staged src. Then go to SETTLE with counter reloaded.
- SETTLE: count BLANK_CYCLES cycles. On exit, output_active_out[idx] <= staged actv[idx], then advance.
- DONE (1 cycle): done_out=1, then go to IDLE.
- Select outputs hold their last value outside WRITE.
- Latency: 1 + N_OUT + R×(2×BLANK_CYCLES+1) cycles from commit to done_out, where R = number of rerouted channels.

Decomposition:
- Shared package router_seq_pkg holds:
  - FSM state encoding: IDLE, SCAN, BLANK, WRITE, SETTLE, DONE.
  - W_CNT=8 for the blank counter.
- Sub-module: none needed; the counter is inline. The staged/live tables are register arrays (N_OUT small).

Test Plan:
- Reset with ACTV_INIT=1 → output_active_out=8'hFF, req_ready_out=1, update_out never pulses, err_out=0.
- Request {src=3, dest=2, actv=1}, commit at cycle 0 (BLANK_CYCLES=4):
  - output_active_out[2]=0 during cycles 4–12.
  - update_out=1 with src_select_out=3, dest_select_out=2 at cycle 8.
  - bit 2 restored at cycle 13.
  - done_out at cycle 18.
- Request {src=0, dest=5, actv=0} (source unchanged), then commit:
  - no update_out pulse.
  - output_active_out[5] drops at scan cycle 6.
  - done_out at cycle 9.
- Request src=9 (≥N_IN) and a separate request with dest=8:
  - both dropped; err_out=1 and stays set.
  - err_clr_in clears it.
  - a later commit produces no update_out.
- Request accepted in the same cycle as commit_in → included in the sequence. A second commit_in and req_valid_in while busy → ignored, req_ready_out=0.
- rst_n_in asserted during BLANK of dest 4 → next cycle IDLE, output_active_out=8'hFF, no update_out. A later commit of the same request reroutes fully.

Source files
------------

// File: rtl/router_seq_pkg.sv
// rtl/router_seq_pkg.sv - shared FSM encoding and counter width for the router sequencer
package router_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_BLANK,
        ST_WRITE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int W_CNT = 8;

endpackage

// File: rtl/router_sequencer.sv
// rtl/router_sequencer.sv - stages route requests and replays changed routes to the router glitch-free
module router_sequencer
    import router_seq_pkg::*;
#(
    parameter int   W_SEL        = 4,
    parameter int   N_IN         = 8,
    parameter int   N_OUT        = 8,
    parameter logic ACTV_INIT    = 1'b1,
    parameter int   BLANK_CYCLES = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               req_valid_in,
    output logic               req_ready_out,
    input  logic [W_SEL-1:0]   req_src_in,
    input  logic [W_SEL-1:0]   req_dest_in,
    input  logic               req_actv_in,
    input  logic               commit_in,
    input  logic               err_clr_in,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out,
    output logic [W_SEL-1:0]   src_select_out,
    output logic [W_SEL-1:0]   dest_select_out,
    output logic               update_out,
    output logic [N_OUT-1:0]   output_active_out
);

    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t             state, next_state;
    logic [W_SEL-1:0]   staged_src [N_OUT];
    logic [W_SEL-1:0]   live_src   [N_OUT];
    logic [N_OUT-1:0]   staged_actv;
    logic [IW-1:0]      idx;
    logic [W_CNT-1:0]   cnt;

    logic               accept, req_ok, changed, last_idx, cnt_done;

    always_comb begin
        next_state = state;
        accept     = req_valid_in && (state == ST_IDLE);
        req_ok     = ({1'b0, req_dest_in} < (W_SEL+1)'(N_OUT)) &&
                     ({1'b0, req_src_in}  < (W_SEL+1)'(N_IN));
        changed    = staged_src[idx] != live_src[idx];
        last_idx   = idx == IW'(N_OUT - 1);
        cnt_done   = cnt == W_CNT'(1);

        case (state)
            ST_IDLE:   if (commit_in) next_state = ST_SCAN;
            ST_SCAN: begin
                if (changed)       next_state = ST_BLANK;
                else if (last_idx) next_state = ST_DONE;
            end
            ST_BLANK:  if (cnt_done) next_state = ST_WRITE;
            ST_WRITE:  next_state = ST_SETTLE;
            ST_SETTLE: if (cnt_done) next_state = last_idx ? ST_DONE : ST_SCAN;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state             <= ST_IDLE;
            idx               <= '0;
            cnt               <= '0;
            staged_actv       <= {N_OUT{ACTV_INIT}};
            output_active_out <= {N_OUT{ACTV_INIT}};
            for (int i = 0; i < N_OUT; i++) begin
                staged_src[i] <= '0;
                live_src[i]   <= '0;
            end
            req_ready_out     <= 1'b1;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            update_out        <= 1'b0;
            err_out           <= 1'b0;
            src_select_out    <= '0;
            dest_select_out   <= '0;
        end else begin
            state         <= next_state;
            // Status outputs are registered from next_state so they line up with the state they describe.
            req_ready_out <= next_state == ST_IDLE;
            busy_out      <= next_state != ST_IDLE;
            update_out    <= next_state == ST_WRITE;
            done_out      <= next_state == ST_DONE;

            if (accept && req_ok) begin
                staged_src[req_dest_in[IW-1:0]]  <= req_src_in;
                staged_actv[req_dest_in[IW-1:0]] <= req_actv_in;
            end

            if (accept && !req_ok)
                err_out <= 1'b1;
            else if (err_clr_in)
                err_out <= 1'b0;

            case (state)
                ST_IDLE: idx <= '0;
                ST_SCAN: begin
                    if (changed) begin
                        output_active_out[idx] <= 1'b0;
                        cnt                    <= W_CNT'(BLANK_CYCLES);
                    end else begin
                        output_active_out[idx] <= staged_actv[idx];
                        idx                    <= idx + 1'b1;
                    end
                end
                ST_BLANK: begin
                    // Selects are loaded on the way into WRITE so they are valid alongside the update pulse.
                    if (cnt_done) begin
                        src_select_out  <= staged_src[idx];
                        dest_select_out <= W_SEL'(idx);
                        live_src[idx]   <= staged_src[idx];
                        cnt             <= W_CNT'(BLANK_CYCLES);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_done) begin
                        output_active_out[idx] <= staged_actv[idx];
                        idx                    <= idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
